// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one
// byte plus odd parity and stop on device clock falls and collects the device ack.
//
// state        | meaning
// IDLE         | lines released, ready for a byte
// INHIBIT      | clock pulled low for INHIBIT_CYCLES
// REQUEST      | clock and data low (start bit) for SETUP_CYCLES
// SEND         | clock released; data/parity/stop driven on device clock falls
// ACK          | sample device ack on the next clock fall
// WAIT_RELEASE | wait for device to release both lines
module ps2_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int SETUP_CYCLES   = 100,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       busy_out,
   output logic       done_out,
   output logic       error_out,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe_out,
   output logic       ps2_data_oe_out
);

   localparam int CMAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {
      IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_RELEASE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [TW-1:0] tmo_cnt;
   logic [3:0]    bit_idx;
   logic [9:0]    frame;
   logic          data_bit;
   logic          nack;
   logic [1:0]    clk_sync, data_sync;
   logic          clk_prev;
   logic          clk_s, data_s, fall;
   logic          accept, tmo_hit, done_nxt, error_nxt;

   // Synchronizers reset high so a reset never manufactures a falling edge.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         clk_prev  <= clk_sync[1];
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];
   assign fall   = clk_prev & ~clk_s;
   assign accept = valid_in && (state == IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      done_nxt        = 1'b0;
      error_nxt       = 1'b0;
      ready_out       = (state == IDLE);
      busy_out        = (state != IDLE);
      ps2_clk_oe_out  = (state == INHIBIT) || (state == REQUEST);
      ps2_data_oe_out = (state == REQUEST) || ((state == SEND) && data_bit);
      tmo_hit         = ((state == SEND) || (state == ACK) || (state == WAIT_RELEASE)) &&
                        (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
      case (state)
         IDLE:         if (valid_in) state_nxt = INHIBIT;
         INHIBIT:      if (cnt == CW'(INHIBIT_CYCLES - 1)) state_nxt = REQUEST;
         REQUEST:      if (cnt == CW'(SETUP_CYCLES - 1)) state_nxt = SEND;
         SEND:         if (fall && (bit_idx == 4'd9)) state_nxt = ACK;
         ACK:          if (fall) state_nxt = WAIT_RELEASE;
         WAIT_RELEASE: if (clk_s && data_s) begin
                          state_nxt = IDLE;
                          done_nxt  = 1'b1;
                          error_nxt = nack;
                       end
         default:      state_nxt = IDLE;
      endcase
      if (tmo_hit) begin
         state_nxt = IDLE;
         done_nxt  = 1'b1;
         error_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt       <= '0;
         tmo_cnt   <= '0;
         bit_idx   <= '0;
         frame     <= '0;
         data_bit  <= 1'b0;
         nack      <= 1'b0;
         done_out  <= 1'b0;
         error_out <= 1'b0;
      end else begin
         done_out  <= done_nxt;
         error_out <= error_nxt;

         if (state_nxt != state)
            cnt <= '0;
         else if ((state == INHIBIT) || (state == REQUEST))
            cnt <= cnt + CW'(1);

         if (state == REQUEST)
            tmo_cnt <= '0;
         else if ((state == SEND) || (state == ACK) || (state == WAIT_RELEASE))
            tmo_cnt <= tmo_cnt + TW'(1);

         if (accept) begin
            frame    <= {1'b1, ~^data_in, data_in};
            bit_idx  <= '0;
            data_bit <= 1'b1;
            nack     <= 1'b0;
         end

         // The pad is pulled low for a 0, so the enable is the inverted bit.
         if ((state == SEND) && fall) begin
            data_bit <= ~frame[bit_idx];
            bit_idx  <= bit_idx + 4'd1;
         end

         if ((state == ACK) && fall)
            nack <= data_s;
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a device model clocks frames out of the host, and
// scoreboard queues hold the expected wire bits and transaction results.
module tb_ps2_tx;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out, busy_out, done_out, error_out;
   logic       ps2_clk_oe_out, ps2_data_oe_out;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_pad, ps2_data_pad;

   int checks = 0;
   int errors = 0;
   logic exp_bits[$];
   logic exp_res[$];

   always #5 clk_in = ~clk_in;

   // Open-drain wired-AND of host and device drivers.
   assign ps2_clk_pad  = ~ps2_clk_oe_out & dev_clk;
   assign ps2_data_pad = ~ps2_data_oe_out & dev_data;

   ps2_tx #(
      .INHIBIT_CYCLES(20),
      .SETUP_CYCLES(4),
      .TIMEOUT_CYCLES(500)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .data_in(data_in),
      .valid_in(valid_in),
      .ready_out(ready_out),
      .busy_out(busy_out),
      .done_out(done_out),
      .error_out(error_out),
      .ps2_clk_in(ps2_clk_pad),
      .ps2_data_in(ps2_data_pad),
      .ps2_clk_oe_out(ps2_clk_oe_out),
      .ps2_data_oe_out(ps2_data_oe_out)
   );

   // Device side: waits for request-to-send, reads start bit, then issues
   // n_clk clocks, reading data on each rising edge; clock 11 carries the ack.
   task automatic dev_run(input int n_clk, input logic ack);
      int   t;
      logic e;
      t = 0;
      while (!(ps2_clk_oe_out === 1'b0 && ps2_data_oe_out === 1'b1) && t < 200) begin
         @(negedge clk_in);
         t++;
      end
      checks++;
      if (t >= 200) begin
         errors++;
         $display("FAIL bfm_request: no request-to-send within %0d cycles", t);
         return;
      end
      repeat (4) @(negedge clk_in);
      for (int i = 0; i <= n_clk; i++) begin
         if (i > 0) begin
            if (i == 11 && ack) dev_data = 1'b0;
            repeat (2) @(negedge clk_in);
            dev_clk = 1'b0;
            repeat (10) @(negedge clk_in);
            dev_clk = 1'b1;
            repeat (2) @(negedge clk_in);
         end
         if (i <= 10) begin
            checks++;
            if (exp_bits.size() == 0) begin
               errors++;
               $display("FAIL frame_bit%0d: got %b, expected queue empty", i, ps2_data_pad);
            end else begin
               e = exp_bits.pop_front();
               if (ps2_data_pad !== e) begin
                  errors++;
                  $display("FAIL frame_bit%0d: got %b, expected %b", i, ps2_data_pad, e);
               end
            end
         end
         if (i == 11) begin
            repeat (3) @(negedge clk_in);
            dev_data = 1'b1;
         end
         repeat (6) @(negedge clk_in);
      end
   endtask

   task automatic wait_done();
      int   t;
      logic e;
      t = 0;
      while (done_out !== 1'b1 && t < 2000) begin
         @(negedge clk_in);
         t++;
      end
      checks++;
      if (t >= 2000) begin
         errors++;
         $display("FAIL done_seen: no done pulse within %0d cycles", t);
         return;
      end
      e = (exp_res.size() != 0) ? exp_res.pop_front() : 1'bx;
      checks++;
      if (error_out !== e) begin
         errors++;
         $display("FAIL done_error: got %b, expected %b", error_out, e);
      end
      checks++;
      if (ready_out !== 1'b1 || ps2_clk_oe_out !== 1'b0 || ps2_data_oe_out !== 1'b0) begin
         errors++;
         $display("FAIL done_idle: ready=%b clk_oe=%b data_oe=%b, expected 1 0 0",
                  ready_out, ps2_clk_oe_out, ps2_data_oe_out);
      end
      @(negedge clk_in);
      checks++;
      if (done_out !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done still %b one cycle later, expected 0", done_out);
      end
   endtask

   task automatic push_frame(input logic [7:0] b);
      logic par;
      par = 1'b1;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_bits.push_back(b[i]);
         par = par ^ b[i];
      end
      exp_bits.push_back(par);
      exp_bits.push_back(1'b1);
   endtask

   task automatic run_xfer(input logic [7:0] b, input logic ack, input logic timing,
                           input logic poke);
      int n, first_d, t;
      push_frame(b);
      exp_res.push_back(~ack);
      data_in  = b;
      valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      data_in  = 8'h00;
      fork
         dev_run(11, ack);
         wait_done();
         begin
            if (timing) begin
               n = 0;
               first_d = 0;
               for (int k = 0; k < 100; k++) begin
                  if (ps2_clk_oe_out === 1'b1) begin
                     n++;
                     if (ps2_data_oe_out === 1'b1 && first_d == 0) first_d = n;
                  end else if (n > 0) break;
                  @(negedge clk_in);
               end
               checks++;
               if (n != 24) begin
                  errors++;
                  $display("FAIL clk_oe_len: got %0d cycles, expected 24", n);
               end
               checks++;
               if (first_d != 21) begin
                  errors++;
                  $display("FAIL data_oe_start: got cycle %0d, expected 21", first_d);
               end
            end
            if (poke) begin
               t = 0;
               while (ps2_clk_oe_out !== 1'b0 && t < 100) begin
                  @(negedge clk_in);
                  t++;
               end
               repeat (30) @(negedge clk_in);
               checks++;
               if (ready_out !== 1'b0) begin
                  errors++;
                  $display("FAIL ready_in_send: got %b, expected 0", ready_out);
               end
               data_in  = 8'h55;
               valid_in = 1'b1;
               @(negedge clk_in);
               valid_in = 1'b0;
               data_in  = 8'h00;
            end
         end
      join
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", ready_out); end
      checks++;
      if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_out); end
      checks++;
      if (ps2_clk_oe_out !== 1'b0 || ps2_data_oe_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_oe: got %b%b, expected 00", ps2_clk_oe_out, ps2_data_oe_out);
      end
      checks++;
      if (done_out !== 1'b0 || error_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got done=%b err=%b, expected 0 0", done_out, error_out);
      end
   endtask

   task automatic test_send_ed();
      run_xfer(8'hED, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_parity();
      run_xfer(8'h00, 1'b1, 1'b0, 1'b0);
      run_xfer(8'h07, 1'b1, 1'b0, 1'b0);
      run_xfer(8'hFF, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_nack();
      run_xfer(8'hF0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      int t, n;
      data_in  = 8'h3C;
      valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      t = 0;
      while (ps2_clk_oe_out !== 1'b0 && t < 100) begin
         @(negedge clk_in);
         t++;
      end
      n = 0;
      while (done_out !== 1'b1 && n < 1000) begin
         @(negedge clk_in);
         n++;
      end
      checks++;
      if (n != 500) begin errors++; $display("FAIL timeout_len: got %0d cycles, expected 500", n); end
      checks++;
      if (error_out !== 1'b1 || ready_out !== 1'b1) begin
         errors++;
         $display("FAIL timeout_flags: got err=%b ready=%b, expected 1 1", error_out, ready_out);
      end
      checks++;
      if (ps2_clk_oe_out !== 1'b0 || ps2_data_oe_out !== 1'b0) begin
         errors++;
         $display("FAIL timeout_oe: got %b%b, expected 00", ps2_clk_oe_out, ps2_data_oe_out);
      end
      repeat (5) @(negedge clk_in);
   endtask

   task automatic test_robustness();
      int ndone;
      run_xfer(8'hA3, 1'b1, 1'b0, 1'b1);
      repeat (50) @(negedge clk_in);
      checks++;
      if (busy_out !== 1'b0) begin errors++; $display("FAIL ignored_valid: busy=%b, expected 0", busy_out); end

      push_frame(8'hA5);
      data_in  = 8'hA5;
      valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      dev_run(4, 1'b1);
      rst_in = 1'b1;
      @(negedge clk_in);
      checks++;
      if (ps2_clk_oe_out !== 1'b0 || ps2_data_oe_out !== 1'b0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_release: got oe=%b%b busy=%b, expected 00 0",
                  ps2_clk_oe_out, ps2_data_oe_out, busy_out);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      exp_bits.delete();
      ndone = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (done_out === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL abort_done: got %0d pulses, expected 0", ndone); end

      run_xfer(8'hF4, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_parity();
      test_nack();
      test_timeout();
      test_robustness();
      repeat (5) @(negedge clk_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
